branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Parametrised direction predictor for the 5-stage RV32I pipelined core; replaces the fixed "backward-taken" rule based on instruction bit 31.
- Decode queries it combinationally with the branch PC and instruction. Execute writes back the resolved outcome using the table index that was carried down the pipe.
- Modes: static BTFN, bimodal, gshare. Counter table is cleared by an internal sweep after reset. Includes branch/hit statistics counters.

Parameters:
MODE, 2, 0 = static BTFN (sign of Bimm), 1 = bimodal, 2 = gshare
INDEX_BITS, 8, log2 of table entries (table = 2^INDEX_BITS counters)
HIST_BITS, 8, global history length; must be <= INDEX_BITS; unused unless MODE = 2
CNT_BITS, 2, saturating counter width; must be >= 2
STAT_BITS, 32, width of statistics counters

Ports:
clk  input  1  core clock
resetn  input  1  synchronous active-low reset
ready  output  1  high once table init sweep is complete
pred_valid  input  1  decode holds a B-type instruction (qualified with !fd_NOP)
pred_PC  input  32  PC of the decode-stage instruction
pred_IR  input  32  decode-stage instruction word
pred_taken  output  1  predicted direction (combinational)
pred_index  output  INDEX_BITS  table index used; core carries it to execute
upd_valid  input  1  execute holds a resolved B-type instruction (one cycle per branch)
upd_index  input  INDEX_BITS  pred_index carried with that branch
upd_taken  input  1  actual outcome (alu take_b)
upd_hit  input  1  actual outcome equals the carried prediction
stat_branches  output  STAT_BITS  number of resolved branches counted
stat_hits  output  STAT_BITS  number of correct predictions counted

Behaviour:
- Reset (resetn low at a clock edge):
  - state <= INIT, init pointer <= 0, GHR <= 0, stat counters <= 0, ready <= 0.
  - Reset asserted mid-sweep or mid-run restarts the sweep from entry 0.
- INIT state:
  - Each cycle writes entry[ptr] = weakly-not-taken (2^(CNT_BITS-1) - 1; 01 for 2-bit), then ptr++.
  - After writing entry 2^INDEX_BITS - 1: state -> RUN, ready = 1 on the following cycle.
  - Sweep takes exactly 2^INDEX_BITS cycles after reset is released.
  - While in INIT: pred_taken = pred_IR[31] (static fallback), updates ignored, stats still count.
- MODE = 0: no table or GHR. ready = 1 from the first cycle after reset. pred_taken = pred_IR[31]. pred_index = 0.
- Index:
  - bimodal: pred_index = pred_PC[INDEX_BITS+1:2].
  - gshare: pred_index = pred_PC[INDEX_BITS+1:2] XOR zero-extended GHR[HIST_BITS-1:0].
- Prediction (RUN): pred_taken = MSB of entry[pred_index]. Combinational from registered table, same-cycle read like the register file.
- Table read/write:
  - Read returns the pre-update value when an update to the same index occurs in that cycle; no bypass.
  - Write takes effect at the clock edge.
- Update (RUN and upd_valid):
  - upd_taken = 1: counter saturating-increments (max 2^CNT_BITS - 1).
  - upd_taken = 0: counter saturating-decrements (min 0).
  - Only entry[upd_index] changes.
- GHR (gshare only):
  - On any upd_valid in RUN: GHR <= {GHR[HIST_BITS-2:0], upd_taken}.
  - Non-speculative. A branch in decode while an older branch is in execute sees history without that older outcome.
  - Core does not repair history on flush.
- Statistics:
  - On each upd_valid: stat_branches++; if upd_hit then stat_hits++.
  - Both saturate at all-ones; no wrap.
- pred_valid is informational only; prediction outputs are driven regardless.
- No stalls generated; block never backpressures the pipeline.

Test Plan:
- MODE = 1, INDEX_BITS = 4: release reset -> ready low exactly 16 cycles, then high. During init, pred_IR[31] = 1 -> pred_taken = 1; after init, pred_PC = 0x40 -> pred_index = 0, pred_taken = 0.
- MODE = 1: four upd_valid with upd_index = 3, upd_taken = 1 -> counter 01->10->11->11; pred_taken for PC 0x0C = 1 after the first update. Then three not-taken -> 11->10->01->00; counter floors at 00 and pred_taken = 0.
- MODE = 2, INDEX_BITS = 4, HIST_BITS = 4: updates taken, taken, not-taken, taken -> GHR = 4'b1101; pred_PC = 0x08 -> pred_index = 0x2 ^ 0xD = 0xF.
- Same-index read/write in one cycle: pred and update both on index 5, counter 01, upd_taken = 1 -> pred_taken = 0 that cycle, 1 the next.
- Stats with STAT_BITS = 4: 20 updates, 17 with upd_hit -> stat_branches = 15 (saturated), stat_hits = 15. Reset mid-sweep at ptr = 7 -> stats 0, sweep restarts, ready rises 16 cycles after release.
- MODE = 0: ready = 1 one cycle after reset; pred_IR = 0xFE000EE3 -> pred_taken = 1; pred_IR = 0x00000463 -> pred_taken = 0; updates leave predictions unchanged.

Source files
------------

// File: rtl/branch_predictor.sv
// branch_predictor: static BTFN / bimodal / gshare direction predictor with init sweep and statistics
module branch_predictor #(
  parameter int MODE       = 2,
  parameter int INDEX_BITS = 8,
  parameter int HIST_BITS  = 8,
  parameter int CNT_BITS   = 2,
  parameter int STAT_BITS  = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  output logic                  ready,
  input  logic                  pred_valid,
  input  logic [31:0]           pred_PC,
  input  logic [31:0]           pred_IR,
  output logic                  pred_taken,
  output logic [INDEX_BITS-1:0] pred_index,
  input  logic                  upd_valid,
  input  logic [INDEX_BITS-1:0] upd_index,
  input  logic                  upd_taken,
  input  logic                  upd_hit,
  output logic [STAT_BITS-1:0]  stat_branches,
  output logic [STAT_BITS-1:0]  stat_hits
);
  localparam logic [CNT_BITS-1:0] WNT = CNT_BITS'((1 << (CNT_BITS - 1)) - 1);
  typedef enum logic {INIT, RUN} state_t;
  state_t state, state_nx;
  logic [INDEX_BITS-1:0] ptr;
  logic unused_ok;
  // pred_valid is informational and some inputs go unused in static mode
  assign unused_ok = ^{pred_valid, pred_PC, pred_IR, upd_index, upd_taken};
  // state register; any reset restarts the clearing sweep
  always_ff @(posedge clk) begin
    if (!resetn) state <= INIT;
    else state <= state_nx;
  end
  // sweep pointer walks the table once while in INIT
  always_ff @(posedge clk) begin
    if (!resetn) ptr <= '0;
    else if (state == INIT) ptr <= ptr + INDEX_BITS'(1);
  end
  // leave INIT after the last entry is written; static mode has no table to clear
  always_comb state_nx = (state == RUN || MODE == 0 || &ptr) ? RUN : INIT;
  // ready follows the state directly
  always_comb ready = state == RUN;
  // saturating branch / hit counters, counting even during the sweep
  always_ff @(posedge clk) begin
    if (!resetn) begin
      stat_branches <= '0;
      stat_hits     <= '0;
    end else if (upd_valid) begin
      if (!(&stat_branches)) stat_branches <= stat_branches + STAT_BITS'(1);
      if (upd_hit && !(&stat_hits)) stat_hits <= stat_hits + STAT_BITS'(1);
    end
  end
  generate
    if (MODE == 0) begin : g_static
      assign pred_taken = pred_IR[31];
      assign pred_index = '0;
    end else begin : g_table
      logic [CNT_BITS-1:0] tbl [2**INDEX_BITS];
      logic [CNT_BITS-1:0] cnt, cnt_nx;
      logic [INDEX_BITS-1:0] hist;
      if (MODE == 2) begin : g_ghr
        logic [HIST_BITS-1:0] ghr;
        // non-speculative global history, shifted only by resolved branches
        always_ff @(posedge clk) begin
          if (!resetn) ghr <= '0;
          else if (state == RUN && upd_valid) ghr <= HIST_BITS'({ghr, upd_taken});
        end
        assign hist = INDEX_BITS'(ghr);
      end else begin : g_nohist
        assign hist = '0;
      end
      // same-cycle table read for decode and saturating next value for execute
      always_comb begin
        pred_index = pred_PC[INDEX_BITS+1:2] ^ hist;
        pred_taken = state == RUN ? tbl[pred_index][CNT_BITS-1] : pred_IR[31];
        cnt        = tbl[upd_index];
        cnt_nx     = upd_taken ? (&cnt ? cnt : cnt + CNT_BITS'(1)) : (|cnt ? cnt - CNT_BITS'(1) : cnt);
      end
      // sweep writes weakly-not-taken; afterwards only resolved branches write
      always_ff @(posedge clk) begin
        if (state == INIT) tbl[ptr] <= WNT;
        else if (upd_valid) tbl[upd_index] <= cnt_nx;
      end
    end
  endgenerate
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: static, bimodal and gshare instances sharing one stimulus stream
module tb_branch_predictor;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic resetn, pred_valid, upd_valid, upd_taken, upd_hit;
  logic [31:0] pred_PC, pred_IR;
  logic [3:0] upd_index;
  logic r0, r1, r2, t0, t1, t2;
  logic [3:0] i0, i1, i2, b0, b1, b2, h0, h1, h2;
  branch_predictor #(.MODE(0), .INDEX_BITS(4), .HIST_BITS(4), .STAT_BITS(4)) u0 (
    .clk(clk), .resetn(resetn), .ready(r0), .pred_valid(pred_valid), .pred_PC(pred_PC),
    .pred_IR(pred_IR), .pred_taken(t0), .pred_index(i0), .upd_valid(upd_valid),
    .upd_index(upd_index), .upd_taken(upd_taken), .upd_hit(upd_hit),
    .stat_branches(b0), .stat_hits(h0));
  branch_predictor #(.MODE(1), .INDEX_BITS(4), .HIST_BITS(4), .STAT_BITS(4)) u1 (
    .clk(clk), .resetn(resetn), .ready(r1), .pred_valid(pred_valid), .pred_PC(pred_PC),
    .pred_IR(pred_IR), .pred_taken(t1), .pred_index(i1), .upd_valid(upd_valid),
    .upd_index(upd_index), .upd_taken(upd_taken), .upd_hit(upd_hit),
    .stat_branches(b1), .stat_hits(h1));
  branch_predictor #(.MODE(2), .INDEX_BITS(4), .HIST_BITS(4), .STAT_BITS(4)) u2 (
    .clk(clk), .resetn(resetn), .ready(r2), .pred_valid(pred_valid), .pred_PC(pred_PC),
    .pred_IR(pred_IR), .pred_taken(t2), .pred_index(i2), .upd_valid(upd_valid),
    .upd_index(upd_index), .upd_taken(upd_taken), .upd_hit(upd_hit),
    .stat_branches(b2), .stat_hits(h2));

  int total = 0, bad = 0;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // reference model: sweep progress, counters as integers, history as a number mod 16
  int m_cyc, m_ghr, m_br, m_hit;
  int m_tbl1[16], m_tbl2[16];
  bit m0_rdy;
  always @(posedge clk) begin
    if (!resetn) begin
      m_cyc <= 0; m_ghr <= 0; m_br <= 0; m_hit <= 0; m0_rdy <= 0;
    end else begin
      m0_rdy <= 1;
      if (upd_valid) begin
        m_br <= m_br < 15 ? m_br + 1 : 15;
        if (upd_hit) m_hit <= m_hit < 15 ? m_hit + 1 : 15;
      end
      if (m_cyc < 16) begin
        m_cyc <= m_cyc + 1;
        if (m_cyc == 15) for (int k = 0; k < 16; k++) begin
          m_tbl1[k] <= 1;
          m_tbl2[k] <= 1;
        end
      end else if (upd_valid) begin
        m_tbl1[upd_index] <= upd_taken ? (m_tbl1[upd_index] < 3 ? m_tbl1[upd_index] + 1 : 3)
                                       : (m_tbl1[upd_index] > 0 ? m_tbl1[upd_index] - 1 : 0);
        m_tbl2[upd_index] <= upd_taken ? (m_tbl2[upd_index] < 3 ? m_tbl2[upd_index] + 1 : 3)
                                       : (m_tbl2[upd_index] > 0 ? m_tbl2[upd_index] - 1 : 0);
        m_ghr <= (m_ghr * 2 + (upd_taken ? 1 : 0)) % 16;
      end
    end
  end

  task automatic cmp_all();
    int x1, x2;
    x1 = int'((pred_PC / 4) % 16);
    x2 = x1 ^ m_ghr;
    check("u0_ready", r0, m0_rdy);
    check("u0_taken", t0, pred_IR[31]);
    check("u0_index", i0, 0);
    check("u1_ready", r1, m_cyc == 16);
    check("u1_index", i1, x1);
    check("u1_taken", t1, m_cyc == 16 ? m_tbl1[x1] >= 2 : pred_IR[31]);
    check("u2_ready", r2, m_cyc == 16);
    check("u2_index", i2, x2);
    check("u2_taken", t2, m_cyc == 16 ? m_tbl2[x2] >= 2 : pred_IR[31]);
    check("u1_branches", b1, m_br);
    check("u1_hits", h1, m_hit);
    check("u2_branches", b2, m_br);
    check("u0_hits", h0, m_hit);
  endtask

  task automatic watch_init(input string tag);
    for (int c = 1; c <= 17; c++) begin
      tick();
      check({tag, "_u1_ready"}, r1, c >= 16);
      check({tag, "_u2_ready"}, r2, c >= 16);
      check({tag, "_u0_ready"}, r0, 1);
      if (c < 16) check({tag, "_fallback"}, t1, pred_IR[31]);
    end
  endtask

  typedef struct {
    logic v, t, h, exp_pt;
    int exp_br, exp_hit;
  } vec_t;
  vec_t vecs[9];

  initial begin
    vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 0, 0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 1, 1};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 2, 1};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 3, 2};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 4, 3};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 5, 3};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 6, 4};
    vecs[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 7, 4};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 8, 5};
    resetn = 0; pred_valid = 1; upd_valid = 0; upd_taken = 0; upd_hit = 0;
    pred_PC = 0; pred_IR = 0; upd_index = 0;
    tick(); tick();
    check("rst_u1_ready", r1, 0);
    check("rst_u0_ready", r0, 0);
    check("rst_branches", b1, 0);
    check("rst_hits", h1, 0);
    pred_IR = 32'h8000_0000;
    resetn = 1;
    watch_init("init");
    pred_PC = 32'h40;
    #1;
    check("run_index", i1, 0);
    check("run_taken", t1, 0);
    pred_IR = 32'hFE00_0EE3; #1;
    check("static_back", t0, 1);
    pred_IR = 32'h0000_0463; #1;
    check("static_fwd", t0, 0);
    check("static_index", i0, 0);
    pred_IR = 32'h8000_0000; pred_PC = 32'h0C; upd_index = 3;
    for (int n = 0; n < 9; n++) begin
      upd_valid = vecs[n].v; upd_taken = vecs[n].t; upd_hit = vecs[n].h;
      #1;
      check($sformatf("vec%0d_taken", n), t1, vecs[n].exp_pt);
      check($sformatf("vec%0d_branches", n), b1, vecs[n].exp_br);
      check($sformatf("vec%0d_hits", n), h1, vecs[n].exp_hit);
      tick();
    end
    check("static_after_upd", t0, 1);
    check("static_idx_after_upd", i0, 0);
    foreach (vecs[n]) if (n < 4) begin
      upd_valid = 1; upd_taken = (n != 2);
      tick();
    end
    upd_valid = 0; pred_PC = 32'h08; #1;
    check("gshare_index", i2, 32'hF);
    check("gshare_taken", t2, 0);
    pred_PC = 32'h14; upd_index = 5; upd_valid = 1; upd_taken = 1; #1;
    check("same_idx_before", t1, 0);
    tick();
    upd_valid = 0; #1;
    check("same_idx_after", t1, 1);
    resetn = 0; tick(); resetn = 1;
    for (int n = 0; n < 20; n++) begin
      upd_valid = 1; upd_hit = n < 17; upd_taken = 1'($urandom);
      tick();
      if (n == 9) check("stat_mid", b1, 10);
    end
    upd_valid = 0; #1;
    check("stat_sat_br", b1, 15);
    check("stat_sat_hit", h1, 15);
    check("stat_sat_br_u2", b2, 15);
    resetn = 0; tick(); resetn = 1;
    repeat (7) tick();
    resetn = 0; tick();
    check("midrst_branches", b1, 0);
    check("midrst_hits", h1, 0);
    check("midrst_ready", r1, 0);
    resetn = 1;
    watch_init("resweep");
    for (int n = 0; n < 800; n++) begin
      resetn = $urandom_range(0, 99) != 0;
      upd_valid = 1'($urandom); upd_taken = 1'($urandom); upd_hit = 1'($urandom);
      upd_index = 4'($urandom); pred_PC = $urandom; pred_IR = $urandom;
      #1;
      cmp_all();
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
